// File: rtl/alu_seq_if.sv
// Command, memory-bus, ALU and register-file signals of the ALU sequencer.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface alu_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_func;
   logic       cmd_rmw;
   logic       rd_req;
   logic       rd_ack;
   logic [7:0] rd_data;
   logic       wr_req;
   logic       wr_ack;
   logic [7:0] wr_data;
   logic [8:0] alu_op;
   logic [7:0] DR;
   logic [7:0] DI;
   logic       C;
   logic [7:0] alu_out;
   logic       alu_C;
   logic       alu_Z;
   logic       alu_N;
   logic       alu_V;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic [3:0] flags;
   logic       done;
   logic       err;

   modport slave (
      input  cmd_valid, cmd_func, cmd_rmw,
      input  rd_ack, rd_data, wr_ack,
      input  alu_out, alu_C, alu_Z, alu_N, alu_V,
      output cmd_ready, rd_req, wr_req, wr_data,
      output alu_op, DR, DI, C,
      output rf_we, rf_wdata, flags, done, err
   );

   modport master (
      output cmd_valid, cmd_func, cmd_rmw,
      output rd_ack, rd_data, wr_ack,
      output alu_out, alu_C, alu_Z, alu_N, alu_V,
      input  cmd_ready, rd_req, wr_req, wr_data,
      input  alu_op, DR, DI, C,
      input  rf_we, rf_wdata, flags, done, err
   );
endinterface

// File: rtl/alu_seq.sv
// ALU command sequencer: operand fetch, single-cycle ALU execute, register or
// memory writeback, flag update. Every output is a registered FSM output.
module alu_seq #(
   parameter int RD_TIMEOUT = 0
) (
   input logic      clk,
   input logic      reset,
   alu_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EXEC,
      WRITE,
      FIN
   } state_t;

   typedef enum logic [3:0] {
      F_ORA = 4'd0,
      F_AND = 4'd1,
      F_EOR = 4'd2,
      F_ADC = 4'd3,
      F_LDA = 4'd4,
      F_CMP = 4'd5,
      F_SBC = 4'd6,
      F_INC = 4'd7,
      F_DEC = 4'd8,
      F_ASL = 4'd9,
      F_ROL = 4'd10,
      F_LSR = 4'd11,
      F_ROR = 4'd12,
      F_PLA = 4'd13,
      F_IL0 = 4'd14,
      F_IL1 = 4'd15
   } func_t;

   localparam bit         TMO_EN   = (RD_TIMEOUT > 0);
   localparam logic [15:0] TMO_LAST = 16'((RD_TIMEOUT > 0) ? RD_TIMEOUT - 1 : 0);

   state_t     state;
   func_t      func_q;
   logic       rmw_q;
   logic       ready_q;
   logic       rd_req_q;
   logic       wr_req_q;
   logic [7:0] wr_data_q;
   logic [8:0] alu_op_q;
   logic [7:0] dr_q;
   logic       rf_we_q;
   logic [7:0] rf_wdata_q;
   logic [3:0] flags_q;
   logic       done_q;
   logic       err_q;
   logic [15:0] tmo_cnt;

   logic       tmo_hit;
   func_t      cmd_f;
   logic       cmd_mem_form;
   logic       cmd_illegal;
   logic       cmd_needs_read;
   logic [3:0] alu_flags;
   logic [3:0] upd_mask;

   // Memory-source variants select DR as the A operand; register variants use A-sel 000.
   function automatic logic [8:0] op_enc(input func_t f, input logic mem);
      logic [2:0] src;
      src = mem ? 3'b001 : 3'b000;
      case (f)
         F_ORA:   return 9'b0_0_100_00_00;
         F_AND:   return 9'b0_0_101_00_00;
         F_EOR:   return 9'b0_0_110_00_00;
         F_ADC:   return 9'b0_0_000_01_10;
         F_SBC:   return 9'b0_0_000_11_10;
         F_CMP:   return 9'b0_0_000_11_01;
         F_LDA:   return 9'b0_0_001_00_00;
         F_INC:   return {2'b00, src, 4'b0001};
         F_DEC:   return {2'b00, src, 4'b1000};
         F_ASL:   return {2'b10, src, 4'b0000};
         F_ROL:   return {2'b10, src, 4'b0011};
         F_LSR:   return {2'b11, src, 4'b0000};
         F_ROR:   return {2'b11, src, 4'b0011};
         F_PLA:   return 9'b0_1_001_00_00;
         default: return '0;
      endcase
   endfunction

   // Which of {N,V,Z,C} a function is allowed to update.
   function automatic logic [3:0] flag_mask(input func_t f);
      case (f)
         F_ADC, F_SBC:                 return 4'b1111;
         F_CMP:                        return 4'b1011;
         F_ASL, F_ROL, F_LSR, F_ROR:   return 4'b1011;
         default:                      return 4'b1010;
      endcase
   endfunction

   assign tmo_hit        = TMO_EN && (tmo_cnt == TMO_LAST);
   assign cmd_f          = func_t'(bus.cmd_func);
   assign cmd_illegal    = (cmd_f == F_IL0) || (cmd_f == F_IL1);
   assign cmd_mem_form   = bus.cmd_rmw && (bus.cmd_func inside {[4'd7:4'd12]});
   assign cmd_needs_read = !(bus.cmd_func inside {[4'd7:4'd12]}) || bus.cmd_rmw;
   assign alu_flags      = {bus.alu_N, bus.alu_V, bus.alu_Z, bus.alu_C};
   assign upd_mask       = flag_mask(func_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         func_q     <= F_ORA;
         rmw_q      <= 1'b0;
         ready_q    <= 1'b1;
         rd_req_q   <= 1'b0;
         wr_req_q   <= 1'b0;
         wr_data_q  <= '0;
         alu_op_q   <= '0;
         dr_q       <= '0;
         rf_we_q    <= 1'b0;
         rf_wdata_q <= '0;
         flags_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         tmo_cnt    <= '0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rf_we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid && ready_q) begin
                  func_q  <= cmd_f;
                  rmw_q   <= cmd_mem_form;
                  ready_q <= 1'b0;
                  tmo_cnt <= '0;
                  if (cmd_illegal) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else if (cmd_needs_read) begin
                     state    <= READ;
                     rd_req_q <= 1'b1;
                  end else begin
                     state    <= EXEC;
                     alu_op_q <= op_enc(cmd_f, cmd_mem_form);
                  end
               end
            end

            READ: begin
               if (bus.rd_ack) begin
                  dr_q     <= bus.rd_data;
                  rd_req_q <= 1'b0;
                  alu_op_q <= op_enc(func_q, rmw_q);
                  state    <= EXEC;
               end else if (tmo_hit) begin
                  rd_req_q <= 1'b0;
                  state    <= FIN;
                  done_q   <= 1'b1;
                  err_q    <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            EXEC: begin
               alu_op_q <= '0;
               flags_q  <= (flags_q & ~upd_mask) | (alu_flags & upd_mask);
               if (rmw_q) begin
                  wr_data_q <= bus.alu_out;
                  wr_req_q  <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= WRITE;
               end else begin
                  // CMP only produces flags; everything else writes the register file.
                  if (func_q != F_CMP) begin
                     rf_wdata_q <= bus.alu_out;
                     rf_we_q    <= 1'b1;
                  end
                  done_q <= 1'b1;
                  state  <= FIN;
               end
            end

            WRITE: begin
               if (bus.wr_ack) begin
                  wr_req_q <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= FIN;
               end else if (tmo_hit) begin
                  wr_req_q <= 1'b0;
                  done_q   <= 1'b1;
                  err_q    <= 1'b1;
                  state    <= FIN;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            FIN: begin
               ready_q <= 1'b1;
               state   <= IDLE;
            end

            default: begin
               rd_req_q <= 1'b0;
               wr_req_q <= 1'b0;
               alu_op_q <= '0;
               ready_q  <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.rd_req    = rd_req_q;
   assign bus.wr_req    = wr_req_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.DR        = dr_q;
   assign bus.DI        = dr_q;
   assign bus.C         = flags_q[0];
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.flags     = flags_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a behavioural ALU stands in for the datapath, and
// a function-level reference model predicts writeback, flags and errors.
module tb_alu_seq;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   rd_wait;
   int   wr_wait;
   logic [7:0] reg_r;
   logic [3:0] m_flags;

   typedef struct {
      bit         err;
      bit         we;
      logic [7:0] wdata;
      bit         wr;
      logic [7:0] wd;
      logic [3:0] flags;
   } exp_t;

   exp_t exp_q[$];

   alu_seq_if bus ();

   alu_seq #(.RD_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALU decoding alu_op per the documented field meanings.
   logic [7:0] alu_a, alu_b, alu_res;
   logic       alu_cin, alu_co, alu_v;
   logic [8:0] alu_sum;
   always_comb begin
      alu_a = '0; alu_b = '0; alu_cin = 1'b0; alu_sum = '0;
      alu_res = '0; alu_co = 1'b0; alu_v = 1'b0;
      case (bus.alu_op[6:4])
         3'b000:  alu_a = reg_r;
         3'b001:  alu_a = bus.DI;
         3'b100:  alu_a = reg_r | bus.DI;
         3'b101:  alu_a = reg_r & bus.DI;
         3'b110:  alu_a = reg_r ^ bus.DI;
         default: alu_a = '0;
      endcase
      case (bus.alu_op[3:2])
         2'b00:   alu_b = 8'h00;
         2'b01:   alu_b = bus.DI;
         2'b10:   alu_b = 8'hFF;
         default: alu_b = ~bus.DI;
      endcase
      case (bus.alu_op[1:0])
         2'b00:   alu_cin = 1'b0;
         2'b01:   alu_cin = 1'b1;
         default: alu_cin = bus.C;
      endcase
      if (bus.alu_op[8]) begin
         if (bus.alu_op[7]) begin
            alu_res = {alu_cin, alu_a[7:1]};
            alu_co  = alu_a[0];
         end else begin
            alu_res = {alu_a[6:0], alu_cin};
            alu_co  = alu_a[7];
         end
      end else if (bus.alu_op[7]) begin
         alu_res = alu_a;
      end else begin
         alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
         alu_res = alu_sum[7:0];
         alu_co  = alu_sum[8];
         alu_v   = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
   end
   assign bus.alu_out = alu_res;
   assign bus.alu_C   = alu_co;
   assign bus.alu_V   = alu_v;
   assign bus.alu_Z   = (alu_res == 8'h00);
   assign bus.alu_N   = alu_res[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: outcome of one command from the instruction-level rules.
   function automatic exp_t model(input logic [3:0] f, input logic rmw,
                                  input logic [7:0] r, input logic [7:0] m,
                                  input logic [3:0] fl);
      exp_t       e;
      int         x, res;
      logic [7:0] res8;
      bit         mem, cy, vv, upd_c, upd_v;
      e.err = 0; e.we = 0; e.wdata = '0; e.wr = 0; e.wd = '0; e.flags = fl;
      if (f > 4'd13) begin
         e.err = 1;
         return e;
      end
      mem = rmw && (f >= 4'd7) && (f <= 4'd12);
      x = mem ? int'(m) : int'(r);
      cy = fl[0]; vv = fl[2]; upd_c = 0; upd_v = 0; res = 0;
      case (f)
         4'd0:  res = r | m;
         4'd1:  res = r & m;
         4'd2:  res = r ^ m;
         4'd3:  begin res = int'(r) + int'(m) + int'(fl[0]); cy = (res > 255); upd_c = 1; upd_v = 1; end
         4'd4:  res = m;
         4'd5:  begin res = int'(r) - int'(m); cy = (r >= m); upd_c = 1; end
         4'd6:  begin
                   res = int'(r) - int'(m) - (1 - int'(fl[0]));
                   cy = (int'(r) + int'(fl[0]) > int'(m)); upd_c = 1; upd_v = 1;
                end
         4'd7:  res = x + 1;
         4'd8:  res = x - 1;
         4'd9:  begin res = x * 2; cy = (x >= 128); upd_c = 1; end
         4'd10: begin res = x * 2 + int'(fl[0]); cy = (x >= 128); upd_c = 1; end
         4'd11: begin res = x / 2; cy = (x % 2 == 1); upd_c = 1; end
         4'd12: begin res = x / 2 + 128 * int'(fl[0]); cy = (x % 2 == 1); upd_c = 1; end
         default: res = m;
      endcase
      res8 = res[7:0];
      if (f == 4'd3) vv = (r[7] == m[7]) && (res8[7] != r[7]);
      if (f == 4'd6) vv = (r[7] != m[7]) && (res8[7] != r[7]);
      e.flags = {res8[7], upd_v ? vv : fl[2], res8 == 8'h00, upd_c ? cy : fl[0]};
      if (mem) begin
         e.wr = 1; e.wd = res8;
      end else if (f != 4'd5) begin
         e.we = 1; e.wdata = res8;
      end
      return e;
   endfunction

   // Memory responders: ack after rd_wait/wr_wait request cycles (0 = same cycle).
   initial begin
      int cnt;
      cnt = 0;
      bus.rd_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.rd_req) begin
            bus.rd_ack = (cnt >= rd_wait);
            cnt++;
         end else begin
            bus.rd_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   initial begin
      int cnt;
      cnt = 0;
      bus.wr_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.wr_req) begin
            bus.wr_ack = (cnt >= wr_wait);
            cnt++;
         end else begin
            bus.wr_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // Compare process: completion outcomes against the model, plus bus invariants.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (bus.rd_req || bus.wr_req || bus.done)
               chk("ready_while_busy", bus.cmd_ready, 1'b0);
            if (bus.rf_we)
               chk("rf_we_with_done", bus.done, 1'b1);
            if (bus.wr_req && exp_q.size() > 0)
               chk("wr_data_during_req", bus.wr_data, exp_q[0].wd);
            if (bus.done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", bus.done, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("err", bus.err, e.err);
                  chk("rf_we", bus.rf_we, e.we);
                  chk("flags", bus.flags, e.flags);
                  chk("C_out", bus.C, e.flags[0]);
                  if (e.we) chk("rf_wdata", bus.rf_wdata, e.wdata);
                  if (e.wr) chk("wr_data", bus.wr_data, e.wd);
               end
            end
         end
      end
   end

   task automatic run_cmd(input string nm, input logic [3:0] f, input logic rmw,
                          input logic [7:0] r, input logic [7:0] m,
                          input int rw, input int ww, input bit tmo,
                          input int exp_lat, input bit exp_rd,
                          input logic [8:0] exp_op, input int exp_wrc);
      exp_t e;
      int   lat, op_cnt, wr_cyc;
      bit   saw_rd;
      logic [8:0] op_seen;
      e = model(f, rmw, r, m, m_flags);
      if (tmo) begin
         e.err = 1; e.we = 0; e.wr = 0; e.flags = m_flags;
      end
      m_flags = e.flags;
      exp_q.push_back(e);
      reg_r = r; bus.rd_data = m; rd_wait = rw; wr_wait = ww;
      bus.cmd_func = f; bus.cmd_rmw = rmw; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = -1; op_cnt = 0; wr_cyc = 0; saw_rd = 0; op_seen = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.alu_op != 9'h000) begin op_cnt++; op_seen = bus.alu_op; end
         if (bus.rd_req) saw_rd = 1;
         if (bus.wr_req) wr_cyc++;
         if (bus.done) begin lat = k; break; end
      end
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_rd_req"}, saw_rd, exp_rd);
      chk({nm, "_wr_cycles"}, wr_cyc, exp_wrc);
      chk({nm, "_op_cycles"}, op_cnt, (exp_op != 9'h000) ? 1 : 0);
      if (exp_op != 9'h000) chk({nm, "_alu_op"}, op_seen, exp_op);
      @(posedge clk); #1;
   endtask

   initial begin
      errors = 0; checks = 0; rd_wait = 0; wr_wait = 0;
      reg_r = '0; m_flags = '0;
      bus.cmd_valid = 1'b0; bus.cmd_func = '0; bus.cmd_rmw = 1'b0; bus.rd_data = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
      chk("rst_rd_req", bus.rd_req, 1'b0);
      chk("rst_wr_req", bus.wr_req, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_flags", bus.flags, 4'h0);
      chk("rst_alu_op", bus.alu_op, 9'h000);
      chk("rst_DR", bus.DR, 8'h00);
      chk("rst_rf_wdata", bus.rf_wdata, 8'h00);
      @(posedge clk); #1;

      //       name   f      rmw r      m      rw  ww tmo lat rd op      wrc
      run_cmd("cmp", 4'd5,  0, 8'h40, 8'h40, 0,  0, 0,  3, 1, 9'h00D, 0);
      chk("cmp_flags_lit", bus.flags, 4'b0011);
      chk("cmp_model_lit", m_flags, 4'b0011);
      run_cmd("ror", 4'd12, 1, 8'h00, 8'h01, 0,  2, 0,  6, 1, 9'h193, 3);
      chk("ror_wr_data_lit", bus.wr_data, 8'h80);
      chk("ror_flags_lit", bus.flags, 4'b1001);
      run_cmd("adc", 4'd3,  0, 8'h7F, 8'h00, 0,  0, 0,  3, 1, 9'h006, 0);
      chk("adc_rf_wdata_lit", bus.rf_wdata, 8'h80);
      chk("adc_flags_lit", bus.flags, 4'b1100);
      run_cmd("lsr", 4'd11, 0, 8'h01, 8'h55, 0,  0, 0,  2, 0, 9'h180, 0);
      chk("lsr_rf_wdata_lit", bus.rf_wdata, 8'h00);
      chk("lsr_flags_lit", bus.flags, 4'b0111);
      run_cmd("ill", 4'd14, 0, 8'h00, 8'h00, 0,  0, 0,  1, 0, 9'h000, 0);
      chk("ill_flags_lit", bus.flags, 4'b0111);
      run_cmd("ora", 4'd0,  0, 8'h0F, 8'hF0, 0,  0, 0,  3, 1, 9'h040, 0);
      run_cmd("sbc", 4'd6,  0, 8'h50, 8'h70, 0,  0, 0,  3, 1, 9'h00E, 0);
      chk("sbc_rf_wdata_lit", bus.rf_wdata, 8'hE0);
      run_cmd("inc", 4'd7,  1, 8'h00, 8'hFF, 0,  0, 0,  4, 1, 9'h011, 1);
      run_cmd("dec", 4'd8,  0, 8'h00, 8'h00, 0,  0, 0,  2, 0, 9'h008, 0);
      run_cmd("rol", 4'd10, 0, 8'h80, 8'h00, 0,  0, 0,  2, 0, 9'h103, 0);
      run_cmd("pla", 4'd13, 0, 8'h00, 8'h00, 2,  0, 0,  5, 1, 9'h090, 0);
      run_cmd("and", 4'd1,  0, 8'hF0, 8'h3C, 0,  0, 0,  3, 1, 9'h050, 0);
      run_cmd("eor", 4'd2,  0, 8'hAA, 8'hAA, 0,  0, 0,  3, 1, 9'h060, 0);
      run_cmd("lda", 4'd4,  0, 8'h00, 8'h81, 0,  0, 0,  3, 1, 9'h010, 0);
      run_cmd("asl", 4'd9,  1, 8'h00, 8'h81, 0,  0, 0,  4, 1, 9'h110, 1);
      chk("asl_flags_lit", bus.flags, 4'b0001);
      run_cmd("tmo", 4'd3,  0, 8'h01, 8'h01, 1000, 0, 1, 5, 1, 9'h000, 0);
      chk("tmo_flags_lit", bus.flags, 4'b0001);

      // Reset while a read is outstanding abandons the command.
      rd_wait = 1000; bus.rd_data = 8'h33;
      bus.cmd_func = 4'd4; bus.cmd_rmw = 1'b0; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_rd_req_before", bus.rd_req, 1'b1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_rd_req", bus.rd_req, 1'b0);
      chk("rstmid_cmd_ready", bus.cmd_ready, 1'b1);
      chk("rstmid_flags", bus.flags, 4'h0);
      chk("rstmid_done", bus.done, 1'b0);
      m_flags = 4'h0;
      @(posedge clk); #1;
      run_cmd("post_rst_lda", 4'd4, 0, 8'h00, 8'h00, 0, 0, 0, 3, 1, 9'h010, 0);
      chk("post_rst_flags_lit", bus.flags, 4'b0010);
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencer that drives the 8-bit ALU's control/data inputs: turns one ALU-class command into an alu_op word, fetches the memory operand, and writes back the result and flags.
- Sits between decode and the combinational ALU, the register file write port and the memory bus.
- Covers register and read-modify-write (RMW) forms of logic, arithmetic, inc/dec, shift/rotate and PLA-style bypass.

Parameters:
- RD_TIMEOUT, 0, cycles to wait for rd_ack/wr_ack before aborting with err; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid&cmd_ready
- cmd_func  in  4  0 ORA,1 AND,2 EOR,3 ADC,4 LDA,5 CMP,6 SBC,7 INC,8 DEC,9 ASL,10 ROL,11 LSR,12 ROR,13 PLA,14-15 illegal
- cmd_rmw  in  1  for funcs 7-12: 1=memory operand and destination, 0=register; ignored otherwise
- rd_req  out  1  operand read request
- rd_ack  in  1  read data valid
- rd_data  in  8  read data
- wr_req  out  1  RMW write request
- wr_ack  in  1  write accepted
- wr_data  out  8  RMW result
- alu_op  out  9  to ALU: [8]shift [7]right [6:4]A-sel [3:2]B-sel [1:0]carry-sel
- DR  out  8  latched operand to ALU
- DI  out  8  bypass input to ALU; equals DR
- C  out  1  carry flag to ALU
- alu_out  in  8  ALU result
- alu_C, alu_Z, alu_N, alu_V  in  1 each  ALU flags
- rf_we  out  1  register write strobe, one cycle
- rf_wdata  out  8  register write data
- flags  out  4  {N,V,Z,C}
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: illegal func or timeout

Behaviour:
- Reset: state IDLE; rd_req=wr_req=rf_we=done=err=0; DR=0; wr_data=rf_wdata=0; flags=0; alu_op=0.
- Reset mid-operation: the command is abandoned, requests drop at that edge, no writeback, no flag change.
- FSM states: IDLE, READ, EXEC, WRITE, FIN.
- IDLE, on accept: latch func/rmw. Illegal func -> FIN with err=1. Funcs 0-6, 13, or 7-12 with rmw=1 -> READ. Otherwise -> EXEC.
- READ: rd_req=1 from the first cycle. On rd_ack, DR<=rd_data and go to EXEC. Ack in the first req cycle is legal.
- EXEC: exactly one cycle; alu_op is valid and the ALU outputs are sampled at its end.
  - Non-RMW, except CMP: rf_wdata<=alu_out.
  - RMW: wr_data<=alu_out, then WRITE.
  - All others go to FIN.
- Flag update at the EXEC edge, other flags held:
  - ADC/SBC: NVZC.
  - CMP: NZC.
  - ORA/AND/EOR/LDA/INC/DEC/PLA: NZ.
  - Shifts/rotates: NZC.
- WRITE: wr_req=1 until wr_ack, then FIN.
- FIN: done=1 for one cycle; rf_we=1 if writeback is pending; -> IDLE.
- Timeout: with RD_TIMEOUT>0, RD_TIMEOUT cycles without ack in READ/WRITE -> FIN with err=1, no writeback, flags unchanged.
- alu_op encodings (register-source variants of 7-12 use A-sel 000 instead of 001):
  - ORA 0_0_100_00_00; AND 0_0_101_00_00; EOR 0_0_110_00_00.
  - ADC 0_0_000_01_10; SBC 0_0_000_11_10; CMP 0_0_000_11_01.
  - LDA 0_0_001_00_00; INC 0_0_001_00_01; DEC 0_0_001_10_00.
  - ASL 1_0_001_00_00; ROL 1_0_001_00_11; LSR 1_1_001_00_00; ROR 1_1_001_00_11.
  - PLA 0_1_001_00_00.
- alu_op=0 outside EXEC.
- Latency, register op with read and zero-wait ack: accept T, rd_req T+1, EXEC T+2, done/rf_we T+3. Without read: EXEC T+1, done T+2.
- cmd_valid while busy is not accepted. Acks outside READ/WRITE are ignored.

Test Plan:
- C=1, R=0x7F, ADC with rd_data=0x00 -> rf_wdata=0x80, rf_we pulses; flags N=1 V=1 Z=0 C=0.
- R=0x40, CMP with rd_data=0x40 -> Z=1 C=1 N=0; no rf_we; done at T+3 with zero-wait ack.
- C=1, ROR rmw with rd_data=0x01 -> wr_data=0x80; N=1 C=1; wr_req held 3 cycles until wr_ack; no rf_we.
- LSR rmw=0 with R=0x01 -> no rd_req; rf_wdata=0x00; Z=1 C=1; done at T+2.
- cmd_func=14 -> done=1 and err=1 at T+1; flags, rf_we and bus requests unchanged.
- reset=0 while rd_req is high -> next cycle rd_req=0, state IDLE, cmd_ready=1, flags=0.
- RD_TIMEOUT=4, rd_ack never asserted -> done=1 and err=1 after 4 req cycles; no writeback.
